// File: rtl/mmio_uart_ctrl.sv
// mmio_uart_ctrl: MMIO responder with UART TX FIFO, RX holding register and cycle/instret counters
module mmio_uart_ctrl #(
  parameter int TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        inst_retired,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);
  localparam int AW = $clog2(TX_DEPTH);
  logic [7:0]    tx_mem [TX_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   tx_cnt;
  logic [7:0]    rx_byte, off;
  logic [31:0]   cyc_cnt, inst_cnt, rd_data;
  logic          rx_full, ld, st, tx_full, push, pop, rx_cap, rx_pop, cnt_clr;
  assign uart_tx_valid = tx_cnt != '0;
  assign uart_tx_data  = tx_mem[rd_ptr];
  assign uart_rx_ready = ~rx_full;
  always_comb begin
    off     = addr[7:0];
    ld      = en & ~|we;
    st      = en & |we;
    tx_full = tx_cnt == (AW+1)'(TX_DEPTH);
    push    = st & (off == 8'h08) & ~tx_full;
    pop     = uart_tx_valid & uart_tx_ready;
    rx_cap  = uart_rx_valid & ~rx_full;
    rx_pop  = ld & (off == 8'h04) & rx_full;
    cnt_clr = st & (off == 8'h18);
    rd_data = off == 8'h00 ? {30'b0, rx_full, ~tx_full} :
              off == 8'h04 ? {24'b0, rx_byte} :
              off == 8'h10 ? cyc_cnt :
              off == 8'h14 ? inst_cnt : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TX_DEPTH; i++) tx_mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tx_cnt   <= '0;
      rx_full  <= 1'b0;
      rx_byte  <= '0;
      cyc_cnt  <= '0;
      inst_cnt <= '0;
      dout     <= '0;
    end else begin
      if (push) tx_mem[wr_ptr] <= din[7:0];
      wr_ptr   <= wr_ptr + AW'(push);
      rd_ptr   <= rd_ptr + AW'(pop);
      tx_cnt   <= tx_cnt + (AW+1)'(push) - (AW+1)'(pop);
      rx_full  <= rx_cap | (rx_full & ~rx_pop);
      if (rx_cap) rx_byte <= uart_rx_data;
      cyc_cnt  <= cnt_clr ? '0 : cyc_cnt + 32'd1;
      inst_cnt <= cnt_clr ? '0 : inst_cnt + 32'(inst_retired);
      if (ld) dout <= rd_data;
    end
  end
endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// tb_mmio_uart_ctrl: directed vector table, collision/counter sequences and a random run vs a queue-based model
module tb_mmio_uart_ctrl;
  localparam int DEPTH = 4;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, inst_retired = 1'b0;
  logic [3:0]  we = '0;
  logic [31:0] addr = '0, din = '0, dout;
  logic [7:0]  uart_tx_data, uart_rx_data = '0;
  logic        uart_tx_valid, uart_tx_ready = 1'b0, uart_rx_valid = 1'b0, uart_rx_ready;

  mmio_uart_ctrl #(.TX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din), .dout(dout),
    .inst_retired(inst_retired), .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [7:0]  txq[$];
  logic        m_rx_full;
  logic [7:0]  m_rx_byte;
  logic [31:0] m_cyc, m_inst, m_dout;
  logic        seen_v;
  logic [7:0]  seen_d;

  typedef struct {
    logic en; logic [3:0] we; logic [7:0] a; logic [31:0] d;
    logic txr; logic rxv; logic [7:0] rxd;
    logic [31:0] e_dout; logic e_txv; logic [7:0] e_txd; logic e_rxr;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Applies the register-map rules to the inputs just sampled by the clock edge
  task automatic model_step();
    logic ld, st;
    logic [7:0] off;
    if (rst) begin
      txq.delete();
      m_rx_full = 0; m_rx_byte = 0; m_cyc = 0; m_inst = 0; m_dout = 0;
      return;
    end
    ld = en && we == 0;
    st = en && we != 0;
    off = addr[7:0];
    if (ld) begin
      if (off == 8'h00) m_dout = {30'b0, m_rx_full, txq.size() < DEPTH};
      else if (off == 8'h04) m_dout = {24'b0, m_rx_byte};
      else if (off == 8'h10) m_dout = m_cyc;
      else if (off == 8'h14) m_dout = m_inst;
      else m_dout = 0;
    end
    if (st && off == 8'h08 && txq.size() < DEPTH) begin
      if (txq.size() > 0 && uart_tx_ready) void'(txq.pop_front());
      txq.push_back(din[7:0]);
    end else if (txq.size() > 0 && uart_tx_ready) void'(txq.pop_front());
    if (ld && off == 8'h04 && m_rx_full) m_rx_full = 0;
    else if (uart_rx_valid && !m_rx_full) begin
      m_rx_full = 1;
      m_rx_byte = uart_rx_data;
    end
    if (st && off == 8'h18) begin
      m_cyc = 0; m_inst = 0;
    end else begin
      m_cyc++;
      m_inst += 32'(inst_retired);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input logic txr, input logic rxv, input logic [7:0] rxd,
                      input logic ret);
    @(negedge clk);
    seen_v = uart_tx_valid;
    seen_d = uart_tx_data;
    rst = r; en = e; we = w; addr = a; din = d;
    uart_tx_ready = txr; uart_rx_valid = rxv; uart_rx_data = rxd; inst_retired = ret;
    @(posedge clk);
    model_step();
    #1;
    chk("model_dout", dout, m_dout);
    chk("model_tx_valid", 32'(uart_tx_valid), 32'(txq.size() > 0));
    if (txq.size() > 0) chk("model_tx_data", 32'(uart_tx_data), 32'(txq[0]));
    chk("model_rx_ready", 32'(uart_rx_ready), 32'(!m_rx_full));
  endtask

  task automatic idle(input logic txr);
    step(0, 0, 4'h0, 32'h8000_0000, 0, txr, 0, 0, 0);
  endtask

  task automatic reset2();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain(output int n, output logic [7:0] last, output logic [7:0] first);
    n = 0; last = 0; first = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (seen_v) begin
        if (n == 0) first = seen_d;
        last = seen_d;
        n++;
      end
    end
  endtask

  initial begin
    int n;
    logic [7:0] last, first;
    logic [7:0] a8;
    logic [3:0] w;
    tv.push_back('{1, 4'h0, 8'h00, 32'h0,        0, 0, 8'h00, 32'h1,  0, 8'h00, 1});
    tv.push_back('{0, 4'hF, 8'h08, 32'h99,       0, 0, 8'h00, 32'h1,  0, 8'h00, 1});
    tv.push_back('{1, 4'hF, 8'h08, 32'h41,       0, 0, 8'h00, 32'h1,  1, 8'h41, 1});
    tv.push_back('{1, 4'h1, 8'h08, 32'hFF42,     0, 0, 8'h00, 32'h1,  1, 8'h41, 1});
    tv.push_back('{1, 4'hF, 8'h08, 32'h43,       0, 0, 8'h00, 32'h1,  1, 8'h41, 1});
    tv.push_back('{1, 4'hF, 8'h08, 32'h44,       0, 0, 8'h00, 32'h1,  1, 8'h41, 1});
    tv.push_back('{1, 4'h0, 8'h00, 32'h0,        0, 0, 8'h00, 32'h0,  1, 8'h41, 1});
    tv.push_back('{1, 4'hF, 8'h08, 32'h45,       0, 0, 8'h00, 32'h0,  1, 8'h41, 1});
    tv.push_back('{1, 4'h0, 8'h0C, 32'h0,        0, 0, 8'h00, 32'h0,  1, 8'h41, 1});
    tv.push_back('{1, 4'h0, 8'h08, 32'h0,        0, 0, 8'h00, 32'h0,  1, 8'h41, 1});
    tv.push_back('{0, 4'h0, 8'h00, 32'h0,        1, 0, 8'h00, 32'h0,  1, 8'h42, 1});
    tv.push_back('{0, 4'h0, 8'h00, 32'h0,        1, 0, 8'h00, 32'h0,  1, 8'h43, 1});
    tv.push_back('{0, 4'h0, 8'h00, 32'h0,        1, 0, 8'h00, 32'h0,  1, 8'h44, 1});
    tv.push_back('{0, 4'h0, 8'h00, 32'h0,        1, 0, 8'h00, 32'h0,  0, 8'h00, 1});
    tv.push_back('{0, 4'h0, 8'h00, 32'h0,        0, 1, 8'hA5, 32'h0,  0, 8'h00, 0});
    tv.push_back('{1, 4'h0, 8'h00, 32'h0,        0, 1, 8'h5A, 32'h3,  0, 8'h00, 0});
    tv.push_back('{1, 4'h0, 8'h04, 32'h0,        0, 1, 8'h5A, 32'hA5, 0, 8'h00, 1});
    tv.push_back('{1, 4'h0, 8'h00, 32'h0,        0, 1, 8'h5A, 32'h1,  0, 8'h00, 0});
    tv.push_back('{1, 4'h0, 8'h04, 32'h0,        0, 0, 8'h00, 32'h5A, 0, 8'h00, 1});
    tv.push_back('{1, 4'h0, 8'h04, 32'h0,        0, 0, 8'h00, 32'h5A, 0, 8'h00, 1});
    tv.push_back('{1, 4'hF, 8'h18, 32'h0,        0, 0, 8'h00, 32'h5A, 0, 8'h00, 1});
    tv.push_back('{1, 4'h0, 8'h10, 32'h0,        0, 0, 8'h00, 32'h0,  0, 8'h00, 1});
    tv.push_back('{1, 4'h0, 8'h14, 32'h0,        0, 0, 8'h00, 32'h0,  0, 8'h00, 1});
    tv.push_back('{1, 4'h0, 8'h10, 32'h0,        0, 0, 8'h00, 32'h2,  0, 8'h00, 1});
    tv.push_back('{1, 4'hF, 8'h10, 32'hFFFFFFFF, 0, 0, 8'h00, 32'h2,  0, 8'h00, 1});
    tv.push_back('{1, 4'h0, 8'h10, 32'h0,        0, 0, 8'h00, 32'h4,  0, 8'h00, 1});

    reset2();
    chk("reset_dout", dout, 0);
    chk("reset_tx_valid", 32'(uart_tx_valid), 0);
    chk("reset_tx_data", 32'(uart_tx_data), 0);
    chk("reset_rx_ready", 32'(uart_rx_ready), 1);
    foreach (tv[i]) begin
      step(0, tv[i].en, tv[i].we, 32'h8000_0000 | 32'(tv[i].a), tv[i].d, tv[i].txr, tv[i].rxv, tv[i].rxd, 0);
      chk($sformatf("vec%0d_dout", i), dout, tv[i].e_dout);
      chk($sformatf("vec%0d_tx_valid", i), 32'(uart_tx_valid), 32'(tv[i].e_txv));
      if (tv[i].e_txv) chk($sformatf("vec%0d_tx_data", i), 32'(uart_tx_data), 32'(tv[i].e_txd));
      chk($sformatf("vec%0d_rx_ready", i), 32'(uart_rx_ready), 32'(tv[i].e_rxr));
    end

    // Push into a full FIFO while it pops: byte must be dropped
    reset2();
    for (int i = 0; i < 4; i++) step(0, 1, 4'hF, 32'h8000_0008, 32'h41 + i, 0, 0, 0, 0);
    step(0, 1, 4'hF, 32'h8000_0008, 32'h55, 1, 0, 0, 0);
    drain(n, last, first);
    chk("full_collision_count", n, 3);
    chk("full_collision_first", 32'(first), 32'h42);
    chk("full_collision_last", 32'(last), 32'h44);

    // Push and pop together on a partly filled FIFO
    reset2();
    step(0, 1, 4'hF, 32'h8000_0008, 32'h61, 0, 0, 0, 0);
    step(0, 1, 4'hF, 32'h8000_0008, 32'h62, 0, 0, 0, 0);
    step(0, 1, 4'hF, 32'h8000_0008, 32'h55, 1, 0, 0, 0);
    drain(n, last, first);
    chk("half_collision_count", n, 2);
    chk("half_collision_first", 32'(first), 32'h62);
    chk("half_collision_last", 32'(last), 32'h55);

    // 100 cycles, 37 of them retiring
    reset2();
    for (int i = 0; i < 100; i++) step(0, 0, 0, 32'h8000_0010, 0, 0, 0, 0, ((i * 37) % 100) < 37);
    step(0, 1, 4'h0, 32'h8000_0010, 0, 0, 0, 0, 0);
    chk("cycle_count_100", dout, 100);
    step(0, 1, 4'h0, 32'h8000_0014, 0, 0, 0, 0, 0);
    chk("inst_count_37", dout, 37);

    // Reset mid-operation flushes TX and RX
    step(0, 1, 4'hF, 32'h8000_0008, 32'h77, 0, 1, 8'h33, 0);
    step(1, 1, 4'hF, 32'h8000_0008, 32'h78, 1, 1, 8'h34, 1);
    chk("midreset_tx_valid", 32'(uart_tx_valid), 0);
    chk("midreset_rx_ready", 32'(uart_rx_ready), 1);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0: a8 = 8'h00; 1: a8 = 8'h04; 2, 3: a8 = 8'h08; 4: a8 = 8'h10;
        5: a8 = 8'h14; 6: a8 = ($urandom_range(0, 15) == 0) ? 8'h18 : 8'h0C;
        default: a8 = 8'($urandom);
      endcase
      w = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, w,
           {$urandom, a8} >> 0 & 32'hFFFF_FF00 | 32'(a8), $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
